// File: rtl/mul_iter_prefix.sv
// Iterative shift-add MULT/MULTU unit producing the HI/LO pair, one multiplier
// bit per cycle through a Kogge-Stone prefix adder (sum_prefix).

module sum_prefix #(
  parameter int LOGWIDTH = 5
) (
  input  logic [2**LOGWIDTH-1:0] a,
  input  logic [2**LOGWIDTH-1:0] b,
  input  logic                   cin,
  output logic [2**LOGWIDTH-1:0] sum,
  output logic                   cout
);
  localparam int W = 2**LOGWIDTH;

  logic [W-1:0] gen, prop, grp_g, grp_p, nxt_g, nxt_p;

  // Carry-in folds into bit 0's generate, so the prefix tree yields every carry directly.
  always_comb begin
    prop     = a ^ b;
    gen      = a & b;
    grp_g    = gen;
    grp_g[0] = gen[0] | (prop[0] & cin);
    grp_p    = prop;
    nxt_g    = '0;
    nxt_p    = '0;
    for (int l = 0; l < LOGWIDTH; l++) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int i = (1 << l); i < W; i++) begin
        nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-(1<<l)]);
        nxt_p[i] = grp_p[i] & grp_p[i-(1<<l)];
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
  end

  assign sum  = prop ^ {grp_g[W-2:0], cin};
  assign cout = grp_g[W-1];
endmodule

module mul_iter_prefix #(
  parameter int LOGWIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   is_signed,
  input  logic [2**LOGWIDTH-1:0] a,
  input  logic [2**LOGWIDTH-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [2**LOGWIDTH-1:0] hi,
  output logic [2**LOGWIDTH-1:0] lo
);
  localparam int W = 2**LOGWIDTH;
  localparam logic [LOGWIDTH-1:0] LAST = LOGWIDTH'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [W-1:0]        op_a, op_b, acc_hi, acc_lo;
  logic                op_signed;
  logic [LOGWIDTH-1:0] count;

  logic                last, bit_k, subtract, cout, top;
  logic [W-1:0]        addend, sum, next_hi, next_lo;

  // op_b is shifted right every RUN cycle, so bit 0 is always multiplier bit k.
  assign last     = (count == LAST);
  assign bit_k    = op_b[0];
  assign subtract = op_signed & last & bit_k;
  assign addend   = subtract ? ~op_a : (bit_k ? op_a : '0);

  sum_prefix #(.LOGWIDTH(LOGWIDTH)) u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (subtract),
    .sum  (sum),
    .cout (cout)
  );

  // Signed: bit W of the sign-extended sum keeps the shift arithmetic even on overflow.
  assign top     = op_signed ? (acc_hi[W-1] ^ addend[W-1] ^ cout) : cout;
  assign next_hi = {top, sum[W-1:1]};
  assign next_lo = {sum[0], acc_lo[W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      count     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a      <= a;
            op_b      <= b;
            op_signed <= is_signed;
            acc_hi    <= '0;
            acc_lo    <= '0;
            count     <= '0;
            state     <= RUN;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          op_b   <= op_b >> 1;
          count  <= count + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= next_hi;
            lo    <= next_lo;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
